dma_responder: RTL and testbench

DMA_RESPONDER -- requirements
Module: dma_responder

---
 rtl/dma_responder_if.sv | 29 ++
 rtl/dma_responder.sv | 106 ++++++++++
 tb/tb_dma_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_responder_if.sv
// Signal bundle between a DMA initiator/weight memory (master) and dma_responder (slave).
// Holds the request/acknowledge pair, the memory read port and the shared data-bus outputs.
interface dma_responder_if #(
    parameter int MEM_ADDRESS_WIDTH   = 10,
    parameter int LAYER_ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH          = 16
);
    logic                           DMA_read;
    logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address;
    logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count;
    logic                           DMA_ready;
    logic                           mem_read;
    logic [MEM_ADDRESS_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]          mem_data;
    logic [DATA_WIDTH-1:0]          Bus_data;
    logic                           Bus_valid;
    logic                           busy;

    // The master side also stands in for the weight memory, so it drives mem_data.
    modport master (
        output DMA_read, DMA_address, DMA_count, mem_data,
        input  DMA_ready, mem_read, mem_address, Bus_data, Bus_valid, busy
    );

    modport slave (
        input  DMA_read, DMA_address, DMA_count, mem_data,
        output DMA_ready, mem_read, mem_address, Bus_data, Bus_valid, busy
    );
endinterface

// File: rtl/dma_responder.sv
// Burst reader: on a DMA request it streams DMA_count words, starting at DMA_address,
// out of a synchronous weight memory and onto the shared bus, then pulses DMA_ready.
module dma_responder #(
    parameter int MEM_ADDRESS_WIDTH   = 10,
    parameter int LAYER_ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    dma_responder_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [MEM_ADDRESS_WIDTH-1:0]   ADDR_ONE = MEM_ADDRESS_WIDTH'(1);
    localparam logic [LAYER_ADDRESS_WIDTH-1:0] REM_ONE  = LAYER_ADDRESS_WIDTH'(1);

    state_t                         r_state;
    logic [MEM_ADDRESS_WIDTH-1:0]   r_mem_address;
    logic [LAYER_ADDRESS_WIDTH-1:0] r_remaining;
    logic                           r_mem_read;
    logic                           r_read_pending;
    logic                           r_bus_valid;
    logic [DATA_WIDTH-1:0]          r_bus_data;
    logic                           r_dma_ready;
    logic                           r_busy;

    // mem_read/mem_address are loaded on the accepting edge so that the memory reads
    // during the first FETCH cycle; r_read_pending marks the cycle mem_data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_mem_address  <= '0;
            r_remaining    <= '0;
            r_mem_read     <= 1'b0;
            r_read_pending <= 1'b0;
            r_bus_valid    <= 1'b0;
            r_bus_data     <= '0;
            r_dma_ready    <= 1'b0;
            r_busy         <= 1'b0;
        end else if (clk_en) begin
            r_dma_ready    <= 1'b0;
            r_read_pending <= r_mem_read;
            r_bus_valid    <= r_read_pending;
            if (r_read_pending) begin
                r_bus_data <= bus.mem_data;
            end

            case (r_state)
                IDLE: begin
                    if (bus.DMA_read) begin
                        r_busy <= 1'b1;
                        if (bus.DMA_count != '0) begin
                            r_state       <= FETCH;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= bus.DMA_address;
                            r_remaining   <= bus.DMA_count;
                        end else begin
                            r_state     <= DONE;
                            r_remaining <= '0;
                        end
                    end
                end

                // r_remaining counts the word currently on mem_address as well.
                FETCH: begin
                    if (r_remaining == REM_ONE) begin
                        r_state     <= DRAIN;
                        r_mem_read  <= 1'b0;
                        r_remaining <= '0;
                    end else begin
                        r_mem_address <= r_mem_address + ADDR_ONE;
                        r_remaining   <= r_remaining - REM_ONE;
                    end
                end

                DRAIN: begin
                    r_state <= DONE;
                end

                DONE: begin
                    r_state     <= IDLE;
                    r_dma_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DMA_ready   = r_dma_ready;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_address = r_mem_address;
    assign bus.Bus_data    = r_bus_data;
    assign bus.Bus_valid   = r_bus_valid;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder: a weight memory holding word[a] = a + 0x100, and one
// task per scenario covering reset, long/back-to-back bursts, wrap, count 0, clk_en and abort.
module tb_dma_responder;
    logic clk;
    logic rst;
    logic clk_en;
    logic [15:0] mem_q;

    int nCompared;
    int nMismatched;

    logic [15:0] gotData[$];
    logic [9:0]  gotAddr[$];
    int firstValid;
    int lastValid;
    int readyEdge;
    int nValid;

    dma_responder_if #(
        .MEM_ADDRESS_WIDTH(10), .LAYER_ADDRESS_WIDTH(7), .DATA_WIDTH(16)
    ) bus ();

    dma_responder #(
        .MEM_ADDRESS_WIDTH(10), .LAYER_ADDRESS_WIDTH(7), .DATA_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory sharing the responder's clock enable: data one enabled cycle after mem_read.
    initial mem_q = 16'h0000;
    always @(posedge clk) begin
        if (clk_en && bus.mem_read === 1'b1) begin
            mem_q <= 16'h0100 + {6'b000000, bus.mem_address};
        end
    end
    assign bus.mem_data = mem_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records one burst with clk_en held high; edge 0 is the accepting edge.
    task automatic collect_burst(input int maxEdges);
        gotData.delete();
        gotAddr.delete();
        firstValid = -1;
        lastValid  = -1;
        readyEdge  = -1;
        nValid     = 0;
        for (int j = 0; j < maxEdges; j++) begin
            step();
            if (bus.mem_read === 1'b1) gotAddr.push_back(bus.mem_address);
            if (bus.Bus_valid === 1'b1) begin
                if (firstValid < 0) firstValid = j;
                lastValid = j;
                nValid++;
                gotData.push_back(bus.Bus_data);
            end
            if (bus.DMA_ready === 1'b1) begin
                readyEdge = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [29:0] obs;
        rst = 1'b1;
        clk_en = 1'b0;
        bus.DMA_read = 1'b1;
        bus.DMA_address = 10'd10;
        bus.DMA_count = 7'd2;
        step();
        step();
        obs = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
        nCompared++;
        if (obs !== 30'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_disabled_edge: got %h expected %h", obs, 30'h0);
        end
        clk_en = 1'b1;
        step();
        nCompared++;
        if (bus.busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_overrides_request: busy got %b expected 0", bus.busy);
        end
        rst = 1'b0;
        step();
        obs = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
        nCompared++;
        if (obs !== {4'b0101, 10'd10, 16'h0000}) begin
            nMismatched++;
            $display("[TB] FAIL first_accept_after_reset: got %h expected %h", obs, {4'b0101, 10'd10, 16'h0000});
        end
        bus.DMA_read = 1'b0;
        readyEdge = -1;
        for (int j = 0; j < 10; j++) begin
            step();
            if (bus.DMA_ready === 1'b1) begin
                readyEdge = j;
                break;
            end
        end
        nCompared++;
        if (readyEdge !== 3) begin
            nMismatched++;
            $display("[TB] FAIL reset_burst_ready_edge: got %0d expected 3", readyEdge);
        end
        step();
        obs = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
        nCompared++;
        if (obs[29:26] !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL idle_outputs: flags got %b expected 0000", obs[29:26]);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        bus.DMA_address = 10'd1;
        bus.DMA_count = 7'd121;
        bus.DMA_read = 1'b1;
        collect_burst(200);
        nCompared++;
        if (firstValid !== 2 || nValid !== 121 || lastValid !== 122 || readyEdge !== 123) begin
            nMismatched++;
            $display("[TB] FAIL long_burst_timing: first=%0d n=%0d last=%0d ready=%0d expected 2 121 122 123",
                     firstValid, nValid, lastValid, readyEdge);
        end
        ok = (gotData.size() == 121) && (gotAddr.size() == 121);
        for (int i = 0; i < gotData.size() && i < 121; i++) begin
            if (gotData[i] !== 16'(16'h0101 + i)) ok = 1'b0;
            if (i < gotAddr.size() && gotAddr[i] !== 10'(1 + i)) ok = 1'b0;
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("[TB] FAIL long_burst_words: got first %h count %0d expected 0101 count 121",
                     (gotData.size() > 0) ? gotData[0] : 16'hxxxx, gotData.size());
        end
        nCompared++;
        if ({bus.busy, bus.Bus_valid} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL ready_cycle_idle: busy,valid got %b expected 00", {bus.busy, bus.Bus_valid});
        end
        bus.DMA_address = 10'd206;
        bus.DMA_count = 7'd120;
        collect_burst(200);
        nCompared++;
        if (firstValid !== 2 || nValid !== 120 || lastValid !== 121 || readyEdge !== 122) begin
            nMismatched++;
            $display("[TB] FAIL b2b_timing: first=%0d n=%0d last=%0d ready=%0d expected 2 120 121 122",
                     firstValid, nValid, lastValid, readyEdge);
        end
        ok = (gotData.size() == 120) && (gotAddr.size() == 120);
        for (int i = 0; i < gotData.size() && i < 120; i++) begin
            if (gotData[i] !== 16'(16'h01CE + i)) ok = 1'b0;
            if (i < gotAddr.size() && gotAddr[i] !== 10'(206 + i)) ok = 1'b0;
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("[TB] FAIL b2b_words: got first %h count %0d expected 01ce count 120",
                     (gotData.size() > 0) ? gotData[0] : 16'hxxxx, gotData.size());
        end
        bus.DMA_read = 1'b0;
        step();
        nCompared++;
        if ({bus.DMA_ready, bus.busy, bus.mem_read, bus.Bus_valid} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL single_ready_pulse: ready,busy,rd,valid got %b expected 0000",
                     {bus.DMA_ready, bus.busy, bus.mem_read, bus.Bus_valid});
        end
    endtask

    task automatic test_wrap();
        logic [9:0]  expAddr[4];
        logic [15:0] expData[4];
        logic ok;
        expAddr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        expData = '{16'h04FE, 16'h04FF, 16'h0100, 16'h0101};
        bus.DMA_address = 10'd1022;
        bus.DMA_count = 7'd4;
        bus.DMA_read = 1'b1;
        collect_burst(20);
        bus.DMA_read = 1'b0;
        ok = (gotAddr.size() == 4) && (gotData.size() == 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gotAddr.size() && gotAddr[i] !== expAddr[i]) ok = 1'b0;
            if (i < gotData.size() && gotData[i] !== expData[i]) ok = 1'b0;
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("[TB] FAIL wrap_sequence: got %0d addrs first %h expected 4 addrs 3fe,3ff,000,001",
                     gotAddr.size(), (gotAddr.size() > 0) ? gotAddr[0] : 10'hxxx);
        end
        nCompared++;
        if (readyEdge !== 6) begin
            nMismatched++;
            $display("[TB] FAIL wrap_ready_edge: got %0d expected 6", readyEdge);
        end
        step();
    endtask

    task automatic test_zero_count();
        bus.DMA_address = 10'd77;
        bus.DMA_count = 7'd0;
        bus.DMA_read = 1'b1;
        collect_burst(20);
        bus.DMA_read = 1'b0;
        nCompared++;
        if (nValid !== 0 || gotAddr.size() !== 0 || readyEdge !== 1) begin
            nMismatched++;
            $display("[TB] FAIL zero_count: valid=%0d reads=%0d ready=%0d expected 0 0 1",
                     nValid, gotAddr.size(), readyEdge);
        end
        step();
    endtask

    task automatic test_clk_en();
        logic [29:0] snap;
        logic [29:0] obs;
        logic dataOk;
        logic frozenDone;
        int j;
        bus.DMA_address = 10'd50;
        bus.DMA_count = 7'd10;
        bus.DMA_read = 1'b1;
        firstValid = -1;
        lastValid = -1;
        readyEdge = -1;
        nValid = 0;
        dataOk = 1'b1;
        frozenDone = 1'b0;
        j = 0;
        for (int it = 0; it < 40 && readyEdge < 0; it++) begin
            step();
            if (j == 0) bus.DMA_read = 1'b0;
            if (bus.Bus_valid === 1'b1) begin
                if (firstValid < 0) firstValid = j;
                if (bus.Bus_data !== 16'(16'h0132 + nValid)) dataOk = 1'b0;
                nValid++;
                lastValid = j;
            end
            if (bus.DMA_ready === 1'b1) readyEdge = j;
            j++;
            if (nValid == 5 && !frozenDone) begin
                frozenDone = 1'b1;
                snap = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
                clk_en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    obs = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
                    nCompared++;
                    if (obs !== snap) begin
                        nMismatched++;
                        $display("[TB] FAIL clk_en_freeze: got %h expected %h", obs, snap);
                    end
                end
                clk_en = 1'b1;
            end
        end
        nCompared++;
        if (!dataOk || firstValid !== 2 || nValid !== 10 || lastValid !== 11 || readyEdge !== 12) begin
            nMismatched++;
            $display("[TB] FAIL clk_en_resume: data_ok=%b first=%0d n=%0d last=%0d ready=%0d expected 1 2 10 11 12",
                     dataOk, firstValid, nValid, lastValid, readyEdge);
        end
        step();
    endtask

    task automatic test_reset_abort();
        logic [29:0] obs;
        logic sawOutput;
        logic ok;
        bus.DMA_address = 10'd300;
        bus.DMA_count = 7'd85;
        bus.DMA_read = 1'b1;
        nValid = 0;
        for (int it = 0; it < 20 && nValid < 3; it++) begin
            step();
            if (bus.Bus_valid === 1'b1) nValid++;
        end
        nCompared++;
        if (nValid !== 3 || bus.Bus_data !== 16'h022E) begin
            nMismatched++;
            $display("[TB] FAIL abort_third_word: words=%0d data=%h expected 3 022e", nValid, bus.Bus_data);
        end
        rst = 1'b1;
        step();
        obs = {bus.DMA_ready, bus.mem_read, bus.Bus_valid, bus.busy, bus.mem_address, bus.Bus_data};
        nCompared++;
        if (obs !== 30'h0) begin
            nMismatched++;
            $display("[TB] FAIL abort_outputs_cleared: got %h expected %h", obs, 30'h0);
        end
        rst = 1'b0;
        bus.DMA_read = 1'b0;
        sawOutput = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.Bus_valid !== 1'b0 || bus.DMA_ready !== 1'b0 || bus.busy !== 1'b0) sawOutput = 1'b1;
        end
        nCompared++;
        if (sawOutput !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_no_ready: activity got %b expected 0", sawOutput);
        end
        bus.DMA_address = 10'd7;
        bus.DMA_count = 7'd3;
        bus.DMA_read = 1'b1;
        collect_burst(20);
        bus.DMA_read = 1'b0;
        ok = (gotData.size() == 3) && (readyEdge == 5);
        for (int i = 0; i < 3 && i < gotData.size(); i++) begin
            if (gotData[i] !== 16'(16'h0107 + i)) ok = 1'b0;
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("[TB] FAIL after_abort_burst: words=%0d ready=%0d expected 3 words 0107.. ready 5",
                     gotData.size(), readyEdge);
        end
        step();
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst = 1'b1;
        clk_en = 1'b0;
        bus.DMA_read = 1'b0;
        bus.DMA_address = '0;
        bus.DMA_count = '0;
        #1;
        $display("[TB] start");
        test_reset();
        test_back_to_back();
        test_wrap();
        test_zero_count();
        test_clk_en();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
